uart_rx_engine: RTL

- Self-timed, oversampling UART receive engine. Successor to the current receiver top-level, which relies on an external sample_edge and receive_done.
- Generates its own bit timing from a baud×OVERSAMPLE tick.
- Validates start bits, majority-votes every bit, and detects parity, framing, break and overrun conditions.
- Holds a completed character in a receive holding register with a read handshake to the APB register block.

---
 rtl/uart_rx_engine.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_engine.sv
// Self-timed oversampling UART receiver: start validation, 3-sample majority vote,
// parity/framing/break/overrun detection and a single-entry holding register.
module uart_rx_engine #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       utrrst,
   input  logic       sample_tick,
   input  logic       uart_rxd,
   input  logic       loop_txd,
   input  logic       loop,
   input  logic [1:0] wls,
   input  logic       stb,
   input  logic       pen,
   input  logic       eps,
   input  logic       sp,
   input  logic       rx_read,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       break_int,
   output logic       overrun_error,
   output logic       rx_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_V0   = CW'(OVERSAMPLE - 3);
   localparam logic [CW-1:0] CNT_V1   = CW'(OVERSAMPLE - 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_WAIT
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [7:0]             shift_q, shift_d;
   logic [1:0]             samp_q, samp_d;
   logic                   zero_q, zero_d;
   logic                   pe_frame_q, pe_frame_d;
   logic                   fe_frame_q, fe_frame_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   valid_q, valid_d;
   logic                   pe_q, pe_d;
   logic                   fe_q, fe_d;
   logic                   bi_q, bi_d;
   logic                   oe_q, oe_d;

   logic       rxd_s;
   logic       cnt_last;
   logic       bit_val;
   logic       exp_par;
   logic [2:0] last_idx;
   logic       complete;
   logic       frame_brk;
   logic       frame_fe;

   assign rxd_s    = sync_q[SYNC_STAGES-1];
   assign cnt_last = (cnt_q == CNT_LAST);
   assign bit_val  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
   assign exp_par  = sp ? ~eps : (eps ? ^shift_q : ~^shift_q);
   assign last_idx = {1'b0, wls} + 3'd4;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], (loop ? loop_txd : uart_rxd)};
      if (utrrst) begin
         sync_d = '1;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      samp_d     = samp_q;
      zero_d     = zero_q;
      pe_frame_d = pe_frame_q;
      fe_frame_d = fe_frame_q;
      rx_data_d  = rx_data_q;
      valid_d    = valid_q;
      pe_d       = pe_q;
      fe_d       = fe_q;
      bi_d       = bi_q;
      oe_d       = oe_q;
      complete   = 1'b0;
      frame_brk  = 1'b0;
      frame_fe   = 1'b0;

      if (sample_tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxd_s) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end
            end
            S_START: begin
               if (cnt_q == CNT_HALF) begin
                  if (rxd_s) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d    = S_DATA;
                     cnt_d      = '0;
                     bit_idx_d  = '0;
                     shift_d    = '0;
                     zero_d     = 1'b1;
                     pe_frame_d = 1'b0;
                     fe_frame_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DATA, S_PARITY, S_STOP1, S_STOP2: begin
               cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
               if (cnt_q == CNT_V0) samp_d[0] = rxd_s;
               if (cnt_q == CNT_V1) samp_d[1] = rxd_s;
               if (cnt_last) begin
                  if (bit_val) zero_d = 1'b0;
                  case (state_q)
                     S_DATA: begin
                        shift_d[bit_idx_q] = bit_val;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == last_idx) begin
                           state_d = pen ? S_PARITY : S_STOP1;
                        end
                     end
                     S_PARITY: begin
                        pe_frame_d = (bit_val != exp_par);
                        state_d    = S_STOP1;
                     end
                     S_STOP1: begin
                        fe_frame_d = ~bit_val;
                        // An all-zero frame (data, parity and stop) is a line break.
                        if (zero_q && !bit_val) begin
                           complete  = 1'b1;
                           frame_brk = 1'b1;
                           frame_fe  = 1'b1;
                           state_d   = S_BRK_WAIT;
                        end else if (stb) begin
                           state_d = S_STOP2;
                        end else begin
                           complete = 1'b1;
                           frame_fe = ~bit_val;
                           state_d  = S_IDLE;
                        end
                     end
                     default: begin
                        complete = 1'b1;
                        frame_fe = fe_frame_q;
                        state_d  = S_IDLE;
                     end
                  endcase
               end
            end
            S_BRK_WAIT: begin
               if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A read coinciding with completion frees the register for the new character.
      if (complete) begin
         if (!valid_q || rx_read) begin
            rx_data_d = frame_brk ? 8'h00 : shift_d;
            valid_d   = 1'b1;
            pe_d      = pe_frame_d;
            fe_d      = frame_fe;
            bi_d      = frame_brk;
            oe_d      = 1'b0;
         end else begin
            oe_d = 1'b1;
         end
      end else if (rx_read && valid_q) begin
         valid_d = 1'b0;
         pe_d    = 1'b0;
         fe_d    = 1'b0;
         bi_d    = 1'b0;
         oe_d    = 1'b0;
      end

      if (utrrst) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         bit_idx_d  = '0;
         shift_d    = '0;
         samp_d     = '0;
         zero_d     = 1'b0;
         pe_frame_d = 1'b0;
         fe_frame_d = 1'b0;
         rx_data_d  = '0;
         valid_d    = 1'b0;
         pe_d       = 1'b0;
         fe_d       = 1'b0;
         bi_d       = 1'b0;
         oe_d       = 1'b0;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sync_q     <= '1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         samp_q     <= '0;
         zero_q     <= 1'b0;
         pe_frame_q <= 1'b0;
         fe_frame_q <= 1'b0;
         rx_data_q  <= '0;
         valid_q    <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         bi_q       <= 1'b0;
         oe_q       <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         samp_q     <= samp_d;
         zero_q     <= zero_d;
         pe_frame_q <= pe_frame_d;
         fe_frame_q <= fe_frame_d;
         rx_data_q  <= rx_data_d;
         valid_q    <= valid_d;
         pe_q       <= pe_d;
         fe_q       <= fe_d;
         bi_q       <= bi_d;
         oe_q       <= oe_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = valid_q;
   assign parity_error  = pe_q;
   assign frame_error   = fe_q;
   assign break_int     = bi_q;
   assign overrun_error = oe_q;
   assign rx_busy       = (state_q != S_IDLE);

endmodule
